// File: rtl/seg7_pkg.sv
// Shared types and segment encoding for the serial
// 7-segment driver.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } seg7_state_t;

  // Active-low {dp,g..a}; dp off in every entry.
  function automatic logic [7:0] hex2seg(
    input logic [3:0] h
  );
    logic [7:0] s;
    s = SEG_BLANK;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_digit_encode.sv
// One digit of text-mode encoding: nibble plus
// decimal point, gated by enable and blink blanking.
module seg7_digit_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       en_n,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] base;

  assign base = hex2seg(nibble);

  assign seg = (en_n | blank) ? SEG_BLANK :
               {base[7] & ~dp, base[6:0]};

endmodule

// File: rtl/seg7_serial_driver.sv
// Serial driver for a shift-register chain of 7-seg
// digits: frame encode, bit-serial shift, latch strobe.
module seg7_serial_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 24,
  parameter int DIR        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  text,
  input  logic [DIGITS*4-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les_n,
  input  logic [DIGITS-1:0]     blink,
  input  logic [DIGITS*8-1:0]   pixels,
  output logic                  busy,
  output logic                  done,
  output logic                  segclk,
  output logic                  segdt,
  output logic                  segen,
  output logic                  segclr
);

  localparam int NBITS = DIGITS * 8;
  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS);
  localparam logic [DW-1:0] DIV_MAX =
    DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX =
    BW'(NBITS - 1);

  seg7_state_t state;
  seg7_state_t state_nx;

  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [NBITS-1:0]      sr;
  logic [NBITS-1:0]      enc;
  logic [NBITS-1:0]      frame;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  pending;
  logic                  clr_q;
  logic                  done_q;
  logic                  div_last;
  logic                  bit_last;
  logic                  cur_bit;
  logic                  phase;

  assign div_last = (div_cnt == DIV_MAX);
  assign bit_last = (bit_cnt == BIT_MAX);
  assign phase    = blink_cnt[BLINK_BITS-1];
  assign cur_bit  = (DIR != 0) ? sr[0] :
                    sr[NBITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg7_digit_encode u_enc (
      .nibble (hexs[4*i +: 4]),
      .dp     (points[i]),
      .en_n   (les_n[i]),
      .blank  (blink[i] & phase),
      .seg    (enc[8*i +: 8])
    );
  end

  assign frame = text ? enc : pixels;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start | pending) state_nx = LOAD;
      LOAD:
        state_nx = SHIFT_LO;
      SHIFT_LO:
        if (div_last) state_nx = SHIFT_HI;
      SHIFT_HI:
        if (div_last)
          state_nx = bit_last ? LATCH : SHIFT_LO;
      LATCH:
        if (div_last) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      blink_cnt <= '0;
      pending   <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      clr_q     <= 1'b1;
      done_q    <= (state == LATCH) && div_last;
      // IDLE always consumes a queued request.
      if (state == IDLE)  pending <= 1'b0;
      else if (start)     pending <= 1'b1;
      unique case (state)
        LOAD: begin
          sr      <= frame;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT_LO, LATCH: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
        SHIFT_HI: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            bit_cnt <= bit_cnt + 1'b1;
            sr <= (DIR != 0) ?
                  {1'b0, sr[NBITS-1:1]} :
                  {sr[NBITS-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = done_q;
  assign segclk = (state == SHIFT_HI);
  assign segdt  = ((state == SHIFT_LO) ||
                   (state == SHIFT_HI)) & cur_bit;
  assign segen  = (state == LATCH);
  assign segclr = clr_q;

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Bench for seg7_serial_driver: frame-level timeline
// model checked every cycle, plus literal frame checks.
module tb_seg7_serial_driver;

  localparam int DG   = 8;
  localparam int CD   = 2;
  localparam int NB   = DG * 8;
  localparam int FLEN = 1 + NB * 2 * CD + CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          text = 1'b0;
  logic [31:0]   hexs = '0;
  logic [7:0]    points = '0;
  logic [7:0]    les_n = '0;
  logic [7:0]    blink = '0;
  logic [63:0]   pixels = '0;
  logic          busy, done, segclk;
  logic          segdt, segen, segclr;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  seg7_serial_driver #(
    .DIGITS(DG), .CLK_DIV(CD),
    .BLINK_BITS(4), .DIR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .text(text), .hexs(hexs), .points(points),
    .les_n(les_n), .blink(blink), .pixels(pixels),
    .busy(busy), .done(done), .segclk(segclk),
    .segdt(segdt), .segen(segen), .segclr(segclr)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [63:0] model_frame(
    input bit ph
  );
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < DG; i++) begin
      if (!text)
        b = pixels[8*i +: 8];
      else if (les_n[i] || (blink[i] && ph))
        b = 8'hFF;
      else begin
        b = hex_tab[hexs[4*i +: 4]];
        if (points[i]) b[7] = 1'b0;
      end
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // Model: frame position m_t (-1 idle), queued flag,
  // cycles since reset for blink phase.
  int          m_t = -1;
  bit          m_pend = 0;
  int          m_cyc = 0;
  bit          m_clr = 0;
  bit          m_done = 0;
  logic [63:0] m_frame = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_t = -1; m_pend = 0; m_cyc = 0;
      m_clr = 0; m_done = 0;
    end else begin
      m_done = 0;
      m_clr = 1;
      if (m_t >= 0) begin
        if (start) m_pend = 1;
        if (m_t == 0)
          m_frame = model_frame(((m_cyc / 8) % 2) == 1);
        m_t++;
        if (m_t == FLEN) begin
          m_t = -1;
          m_done = 1;
        end
      end else if (start || m_pend) begin
        m_pend = 0;
        m_t = 0;
      end
      m_cyc++;
    end
  end

  // Monitor state
  logic [63:0] cap_frame [$];
  int          cap_busy [$];
  int          cap_en [$];
  int          cap_edge [$];
  logic [63:0] sh = '0;
  int          busy_n = 0, en_n = 0, edge_n = 0;
  int          en_total = 0;
  logic        prev_clk = 1'b0;

  initial forever begin
    logic [5:0] act, exp_v;
    bit e_clk, e_dt, e_en;
    int k;
    @(negedge clk);
    if (chk_on) begin
      e_clk = 0; e_dt = 0; e_en = 0;
      if (m_t >= 1 && m_t <= NB * 2 * CD) begin
        k = m_t - 1;
        e_clk = (k % (2 * CD)) >= CD;
        e_dt  = m_frame[NB - 1 - k / (2 * CD)];
      end
      e_en = (m_t > NB * 2 * CD);
      exp_v = {m_t >= 0, m_done, e_clk,
               e_dt, e_en, m_clr};
      act = {busy, done, segclk, segdt, segen, segclr};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cycle t=%0t bsy/dn/clk/dt/en/clr got %b exp %b",
                 $time, act, exp_v);
      end
    end
    if (segen === 1'b1) en_total++;
    if (rst) begin
      sh = '0; busy_n = 0; en_n = 0; edge_n = 0;
      prev_clk = 1'b0;
    end else begin
      if (segclk === 1'b1 && prev_clk === 1'b0) begin
        sh = {sh[62:0], segdt};
        edge_n++;
      end
      prev_clk = segclk;
      if (busy === 1'b1) busy_n++;
      if (segen === 1'b1) en_n++;
      if (done === 1'b1) begin
        cap_frame.push_back(sh);
        cap_busy.push_back(busy_n);
        cap_en.push_back(en_n);
        cap_edge.push_back(edge_n);
        sh = '0; busy_n = 0; en_n = 0; edge_n = 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got %h exp %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n,
                             input int budget);
    int k;
    k = 0;
    while (cap_frame.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (cap_frame.size() < n) begin
      bad++;
      $display("FAIL wait_frames got %0d need %0d",
               cap_frame.size(), n);
    end
  endtask

  task automatic frame_checks(input string nm,
                              input logic [63:0] e);
    int ix;
    ix = cap_frame.size() - 1;
    if (ix < 0) ix = 0;
    if (cap_frame.size() > 0) begin
      chk({nm, "_first"}, 64'(cap_frame[ix][63:56]),
          64'(e[63:56]));
      chk({nm, "_last"}, 64'(cap_frame[ix][7:0]),
          64'(e[7:0]));
      chk({nm, "_frame"}, cap_frame[ix], e);
      chk({nm, "_busy"}, 64'(cap_busy[ix]), 64'(FLEN));
      chk({nm, "_segen"}, 64'(cap_en[ix]), 64'(CD));
      chk({nm, "_edges"}, 64'(cap_edge[ix]), 64'(NB));
    end
  endtask

  initial begin
    int n0, ebef;
    logic [63:0] mf;
    tick();
    chk_on = 1'b1;
    tick();
    tick();
    @(negedge clk); #1;
    chk("rst_outs",
        64'({busy, done, segclk, segdt, segen, segclr}),
        64'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk); #1;
    chk("rel_clr_busy", 64'({segclr, busy}), 64'b10);

    // Plain hex frame
    text = 1'b1; hexs = 32'h01234567;
    points = '0; les_n = '0; blink = '0;
    mf = model_frame(1'b0);
    chk("model_plain", mf, 64'hC0F9A4B0999282F8);
    n0 = cap_frame.size();
    pulse();
    wait_frames(n0 + 1, 700);
    frame_checks("plain", 64'hC0F9A4B0999282F8);

    // Points and enables
    points = 8'h01; les_n = 8'h80;
    n0 = cap_frame.size();
    pulse();
    wait_frames(n0 + 1, 700);
    frame_checks("pts", 64'hFFF9A4B099928278);

    // Raw mode
    text = 1'b0; points = '0; les_n = '0;
    pixels = 64'h0123456789ABCDEF;
    n0 = cap_frame.size();
    pulse();
    wait_frames(n0 + 1, 700);
    frame_checks("raw", 64'h0123456789ABCDEF);

    // Queueing: three extra starts, one extra frame
    text = 1'b1; hexs = 32'h01234567;
    n0 = cap_frame.size();
    pulse();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 60)) tick();
      pulse();
    end
    hexs = 32'hFEDCBA98;
    wait_frames(n0 + 2, 1000);
    repeat (300) tick();
    chk("queue_count", 64'(cap_frame.size()),
        64'(n0 + 2));
    if (cap_frame.size() >= n0 + 2) begin
      chk("queue_f1", cap_frame[n0],
          64'hC0F9A4B0999282F8);
      chk("queue_f2", cap_frame[n0 + 1],
          64'h8E86A1C683889080);
    end

    // Blink
    hexs = 32'h01234567; blink = 8'h01;
    mf = model_frame(1'b1);
    chk("model_blink_on", 64'(mf[7:0]), 64'hFF);
    mf = model_frame(1'b0);
    chk("model_blink_off", 64'(mf[7:0]), 64'hF8);
    n0 = cap_frame.size();
    for (int i = 0; i < 2; i++) begin
      pulse();
      repeat (20) tick();
      pulse();
      wait_frames(n0 + 2 * (i + 1), 1200);
    end
    for (int i = n0; i < cap_frame.size(); i++)
      chk("blink_b0",
          64'((cap_frame[i][7:0] == 8'hF8) ||
              (cap_frame[i][7:0] == 8'hFF)), 64'd1);

    // Abort mid-shift
    n0 = cap_frame.size();
    ebef = en_total;
    pulse();
    repeat (40) tick();
    rst = 1'b1;
    tick();
    @(negedge clk); #1;
    chk("abort_outs",
        64'({busy, done, segclk, segdt, segen, segclr}),
        64'd0);
    tick();
    rst = 1'b0;
    repeat (300) tick();
    chk("abort_no_latch", 64'(en_total), 64'(ebef));
    chk("abort_no_frame", 64'(cap_frame.size()),
        64'(n0));

    // Randomized frames
    for (int it = 0; it < 8; it++) begin
      text   = 1'($urandom_range(0, 1));
      hexs   = $urandom;
      points = 8'($urandom);
      les_n  = 8'($urandom);
      blink  = 8'($urandom);
      pixels = {$urandom, $urandom};
      pulse();
      repeat ($urandom_range(1, 250)) tick();
      hexs = $urandom;
      pixels = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) pulse();
      repeat (600) tick();
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
